// File: rtl/fft_magnitude_stream_if.sv
// Bin stream bundle between the FFT core, the magnitude stage and the bin-maximum tracker.
// The FFT side drives in_*; the magnitude stage drives out_* and frame_error.
interface fft_magnitude_stream_if #(
  parameter int DATA_WIDTH = 48,
  parameter int MAG_WIDTH  = 96,
  parameter int K_WIDTH    = 12
);
  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] in_re;
  logic signed [DATA_WIDTH-1:0] in_im;
  logic                         in_last;
  logic                         out_valid;
  logic [MAG_WIDTH-1:0]         out_mag;
  logic [K_WIDTH-1:0]           out_k;
  logic                         out_frame_done;
  logic                         frame_error;

  modport master (
    output in_valid, in_re, in_im, in_last,
    input  out_valid, out_mag, out_k, out_frame_done, frame_error
  );

  modport slave (
    input  in_valid, in_re, in_im, in_last,
    output out_valid, out_mag, out_k, out_frame_done, frame_error
  );
endinterface

// File: rtl/fft_magnitude_stream.sv
// Three-stage |X|^2 pipeline with bin index tagging and frame alignment check.
// Define HALF_SPECTRUM_EN to suppress out_valid for mirror bins k >= DEPTH/2.
module fft_magnitude_stream #(
  parameter int DEPTH      = 4096,
  parameter int DATA_WIDTH = 48,
  parameter int MAG_WIDTH  = 96,
  parameter int K_WIDTH    = 12
) (
  input logic                  clock,
  input logic                  reset,
  fft_magnitude_stream_if.slave bus
);

  localparam logic [K_WIDTH-1:0] K_LAST = K_WIDTH'(DEPTH - 1);

  logic [K_WIDTH-1:0]             bin_cnt;
  logic                           vld_p0, vld_p1;
  logic [K_WIDTH-1:0]             k_p0, k_p1;
  logic signed [DATA_WIDTH-1:0]   re_p0, im_p0;
  logic signed [2*DATA_WIDTH-1:0] sq_re_p1, sq_im_p1;
  logic                           mirror_p1;

  function automatic logic signed [2*DATA_WIDTH-1:0] square(input logic signed [DATA_WIDTH-1:0] x);
    logic signed [2*DATA_WIDTH-1:0] xe;
    xe = {{DATA_WIDTH{x[DATA_WIDTH-1]}}, x};
    return xe * xe;
  endfunction

  // Both squares are non-negative and at most 2^(2*DATA_WIDTH-2), so the sum never overflows.
  function automatic logic [MAG_WIDTH-1:0] mag_sum(input logic signed [2*DATA_WIDTH-1:0] a,
                                                   input logic signed [2*DATA_WIDTH-1:0] b);
    return MAG_WIDTH'($unsigned(a)) + MAG_WIDTH'($unsigned(b));
  endfunction

`ifdef HALF_SPECTRUM_EN
  assign mirror_p1 = k_p1[K_WIDTH-1];
`else
  assign mirror_p1 = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      bin_cnt            <= '0;
      vld_p0             <= 1'b0;
      vld_p1             <= 1'b0;
      k_p0               <= '0;
      k_p1               <= '0;
      bus.out_valid      <= 1'b0;
      bus.out_frame_done <= 1'b0;
      bus.out_k          <= '0;
      bus.out_mag        <= '0;
      bus.frame_error    <= 1'b0;
    end else begin
      // S1: tag the accepted bin with its index and check alignment with in_last
      vld_p0 <= bus.in_valid;
      if (bus.in_valid) begin
        k_p0 <= bin_cnt;
        if (bus.in_last && bin_cnt != K_LAST) begin
          bus.frame_error <= 1'b1;
          bin_cnt         <= '0;
        end else begin
          if (!bus.in_last && bin_cnt == K_LAST) bus.frame_error <= 1'b1;
          bin_cnt <= bin_cnt + 1'b1;
        end
      end
      // S2
      vld_p1 <= vld_p0;
      k_p1   <= k_p0;
      // S3: out_k/out_mag hold through bubbles; mirror bins still update them
      bus.out_valid      <= vld_p1 && !mirror_p1;
      bus.out_frame_done <= vld_p1 && (k_p1 == K_LAST);
      if (vld_p1) begin
        bus.out_k   <= k_p1;
        bus.out_mag <= mag_sum(sq_re_p1, sq_im_p1);
      end
    end
  end

  always_ff @(posedge clock) begin
    // S1
    re_p0    <= bus.in_re;
    im_p0    <= bus.in_im;
    // S2
    sq_re_p1 <= square(re_p0);
    sq_im_p1 <= square(im_p0);
  end

endmodule

// File: tb/tb_fft_magnitude_stream.sv
// Directed bench for fft_magnitude_stream: transaction-level model plus literal spot checks.
module tb_fft_magnitude_stream;

`ifdef HALF_SPECTRUM_EN
  localparam bit HALF = 1'b1;
`else
  localparam bit HALF = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   fails   = 0;

  fft_magnitude_stream_if #(.DATA_WIDTH(48), .MAG_WIDTH(96), .K_WIDTH(12)) bus ();

  fft_magnitude_stream #(.DEPTH(4096), .DATA_WIDTH(48), .MAG_WIDTH(96), .K_WIDTH(12)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          v;
    logic [95:0] mag;
    int          k;
  } txn_t;

  txn_t              pipe[$];
  txn_t              mt;
  int                cnt = 0;
  bit                model_on = 1'b0;
  logic              e_valid = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [95:0]       e_mag = '0;
  logic [11:0]       e_k = '0;
  logic signed [127:0] mr, mi;

  // Model: each accepted bin becomes a transaction; the one accepted two edges back is on the outputs.
  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        pipe.delete();
        cnt = 0; e_err = 1'b0; e_valid = 1'b0; e_done = 1'b0; e_mag = '0; e_k = '0;
        model_on = 1'b1;
      end else begin
        mt.v = bus.in_valid; mt.mag = '0; mt.k = 0;
        if (bus.in_valid) begin
          mr = bus.in_re; mi = bus.in_im;
          mt.mag = 96'(mr * mr + mi * mi);
          mt.k = cnt;
          if (bus.in_last && cnt != 4095) begin
            e_err = 1'b1; cnt = 0;
          end else begin
            if (!bus.in_last && cnt == 4095) e_err = 1'b1;
            cnt = (cnt + 1) % 4096;
          end
        end
        pipe.push_back(mt);
        e_valid = 1'b0; e_done = 1'b0;
        if (pipe.size() >= 3) begin
          mt = pipe.pop_front();
          if (mt.v) begin
            e_mag   = mt.mag;
            e_k     = 12'(mt.k);
            e_done  = (mt.k == 4095);
            e_valid = !(HALF && mt.k >= 2048);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (model_on) begin
        chk("out_valid", 96'(bus.out_valid), 96'(e_valid));
        chk("out_k", 96'(bus.out_k), 96'(e_k));
        chk("out_mag", bus.out_mag, e_mag);
        chk("out_frame_done", 96'(bus.out_frame_done), 96'(e_done));
        chk("frame_error", 96'(bus.frame_error), 96'(e_err));
      end
    end
  end

  task automatic drive(input logic v, input logic signed [47:0] re, input logic signed [47:0] im,
                       input logic last);
    @(negedge clock);
    reset = 1'b0;
    bus.in_valid = v; bus.in_re = re; bus.in_im = im; bus.in_last = last;
  endtask

  task automatic bin(input logic signed [47:0] re, input logic signed [47:0] im, input logic last);
    drive(1'b1, re, im, last);
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  logic signed [47:0] most_neg;
  logic [95:0]        two_95;

  initial begin
    bus.in_valid = 1'b0; bus.in_re = '0; bus.in_im = '0; bus.in_last = 1'b0;
    most_neg = 48'sh8000_0000_0000;
    two_95   = 96'd1 << 95;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst out_valid", 96'(bus.out_valid), 96'd0);
    chk("rst out_mag", bus.out_mag, 96'd0);
    chk("rst out_k", 96'(bus.out_k), 96'd0);
    chk("rst out_frame_done", 96'(bus.out_frame_done), 96'd0);
    chk("rst frame_error", 96'(bus.frame_error), 96'd0);

    // Single bin 3 - 4j
    bin(48'sd3, -48'sd4, 1'b0);
    repeat (3) idle();
    chk("single out_valid", 96'(bus.out_valid), 96'd1);
    chk("single out_mag", bus.out_mag, 96'd25);
    chk("single out_k", 96'(bus.out_k), 96'd0);

    // Extremes: both components at the most negative value
    bin(most_neg, most_neg, 1'b0);
    repeat (3) idle();
    chk("extreme out_mag", bus.out_mag, two_95);
    chk("extreme out_k", 96'(bus.out_k), 96'd1);
    idle();
    chk("bubble holds out_mag", bus.out_mag, two_95);

    // Full aligned frame with one idle cycle mid-frame
    do_reset();
    for (int k = 0; k < 4096; k++) begin
      bin(48'(k * 37 - 5000), 48'(12345 - k * 11), k == 4095);
      if (k == 2000) idle();
    end
    repeat (3) idle();
    chk("frame out_k", 96'(bus.out_k), 96'd4095);
    chk("frame out_frame_done", 96'(bus.out_frame_done), 96'd1);
    chk("frame frame_error", 96'(bus.frame_error), 96'd0);
    idle();
    chk("frame_done one cycle", 96'(bus.out_frame_done), 96'd0);

    // in_last on bin 100: error latches, counter resyncs
    do_reset();
    for (int k = 0; k <= 100; k++) bin(48'(k), 48'(-k), k == 100);
    bin(48'sd1, 48'sd1, 1'b0);
    repeat (3) idle();
    chk("misalign out_k", 96'(bus.out_k), 96'd0);
    chk("misalign out_mag", bus.out_mag, 96'd2);
    chk("misalign frame_error", 96'(bus.frame_error), 96'd1);
    for (int k = 0; k < 20; k++) bin(48'(k), 48'sd7, 1'b0);
    repeat (5) idle();
    chk("frame_error sticky", 96'(bus.frame_error), 96'd1);

    // Reset asserted while bin 2000 is presented
    do_reset();
    for (int k = 0; k < 2000; k++) bin(48'(k), 48'(k - 1000), 1'b0);
    @(negedge clock);
    reset = 1'b1;
    bus.in_valid = 1'b1; bus.in_re = 48'sd99; bus.in_im = 48'sd99; bus.in_last = 1'b0;
    @(negedge clock);
    chk("midrst out_valid", 96'(bus.out_valid), 96'd0);
    chk("midrst out_mag", bus.out_mag, 96'd0);
    chk("midrst out_k", 96'(bus.out_k), 96'd0);
    chk("midrst frame_error", 96'(bus.frame_error), 96'd0);
    reset = 1'b0;
    bus.in_valid = 1'b1; bus.in_re = 48'sd5; bus.in_im = 48'sd12;
    idle();
    chk("midrst no stale valid", 96'(bus.out_valid), 96'd0);
    repeat (2) idle();
    chk("postrst out_valid", 96'(bus.out_valid), 96'd1);
    chk("postrst out_mag", bus.out_mag, 96'd169);
    chk("postrst out_k", 96'(bus.out_k), 96'd0);

    repeat (4) idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete, time %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
